// File: rtl/wbs_mbox_fifo.sv
// Wishbone slave mailbox FIFO: 16-bit DATA push/pop, COUNT/STATUS/THRESH/CTRL registers, threshold IRQ.
// Define WBS_MBOX_ERR_EN to terminate full-write, empty-read and unmapped accesses with wb_err_o.
module wbs_mbox_fifo #(
    parameter int unsigned DEPTH_LOG2 = 9
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [4:0]  wb_adr_i,
    input  logic [15:0] wb_dat_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [2:0]  wb_cti_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic        wb_lock_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        int_out
);
    localparam int unsigned CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1 << DEPTH_LOG2);

    localparam logic [3:0] A_DATA   = 4'd0;
    localparam logic [3:0] A_COUNT  = 4'd1;
    localparam logic [3:0] A_STATUS = 4'd2;
    localparam logic [3:0] A_THRESH = 4'd3;
    localparam logic [3:0] A_CTRL   = 4'd4;

    logic                  ack, err, cont;
    logic [15:0]           dat_q;
    logic [CW-1:0]         count, count_next, thresh, mem_cnt;
    logic                  ovf, udf, thr_pend, irq_en, flush_q, int_q;
    logic [DEPTH_LOG2-1:0] wp, rp, ra;
    logic [15:0]           mem [0:(1 << DEPTH_LOG2)-1];
    logic [15:0]           q, byp, head, mq, rdata;
    logic                  head_vld, coll;

    logic [3:0] word;
    logic       acc, is_err, empty, full, wr_data, rd_req, push, pop;
    logic       mem_has, need_fill, rp_adv, mem_we, thr_set, w_status, w_ctrl;
    logic       unused_ok;

    assign unused_ok = ^{wb_lock_i, wb_adr_i[0]};
    assign word      = wb_adr_i[4:1];
    assign wb_ack_o  = ack;
    assign wb_err_o  = err;
    assign wb_rty_o  = 1'b0;
    assign wb_dat_o  = dat_q;
    assign int_out   = int_q;

`ifdef WBS_MBOX_ERR_EN
    assign is_err = (wr_data & full) | (rd_req & empty) | (acc & (word > A_CTRL));
`else
    assign is_err = 1'b0;
`endif

    always_comb begin
        // cont keeps a burst going while ack is still high
        acc        = wb_cyc_i & wb_stb_i & (~(ack | err) | cont);
        empty      = (count == '0);
        full       = (count == DEPTH);
        wr_data    = acc & wb_we_i & (word == A_DATA) & (wb_sel_i == 2'b11);
        rd_req     = acc & ~wb_we_i & (word == A_DATA);
        push       = wr_data & ~full;
        pop        = rd_req & ~empty;
        w_status   = acc & wb_we_i & (word == A_STATUS) & wb_sel_i[0];
        w_ctrl     = acc & wb_we_i & (word == A_CTRL) & wb_sel_i[0];
        // head holds the oldest word; memory holds the rest
        mem_cnt    = count - CW'(head_vld);
        mem_has    = (mem_cnt != '0);
        need_fill  = pop | ~head_vld;
        rp_adv     = need_fill & mem_has & ~flush_q;
        mem_we     = push & ~flush_q & ~(need_fill & ~mem_has);
        ra         = flush_q ? '0 : rp + DEPTH_LOG2'(rp_adv);
        mq         = coll ? byp : q;
        count_next = flush_q ? '0 : count + CW'(push) - CW'(pop);
        thr_set    = (thresh != '0) && (count < thresh) && (count_next >= thresh);
        rdata      = '0;
        case (word)
            A_DATA:   rdata = empty ? '0 : head;
            A_COUNT:  rdata = 16'(count);
            A_STATUS: rdata = {11'b0, thr_pend, udf, ovf, full, empty};
            A_THRESH: rdata = 16'(thresh);
            A_CTRL:   rdata = {14'b0, irq_en, 1'b0};
            default:  rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack      <= 1'b0;
            err      <= 1'b0;
            cont     <= 1'b0;
            dat_q    <= '0;
            count    <= '0;
            thresh   <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
            thr_pend <= 1'b0;
            irq_en   <= 1'b0;
            flush_q  <= 1'b0;
            int_q    <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            head     <= '0;
            head_vld <= 1'b0;
            coll     <= 1'b0;
        end else begin
            ack      <= acc & ~is_err;
            err      <= acc & is_err;
            cont     <= acc & ~is_err & (wb_cti_i == 3'b010);
            dat_q    <= (acc & ~wb_we_i) ? rdata : '0;
            count    <= count_next;
            flush_q  <= w_ctrl & wb_dat_i[0];
            if (w_ctrl)
                irq_en <= wb_dat_i[1];
            if (acc & wb_we_i & (word == A_THRESH) & (|wb_sel_i))
                thresh <= wb_dat_i[CW-1:0];
            ovf      <= (wr_data & full) | (ovf & ~(w_status & wb_dat_i[2]));
            udf      <= (rd_req & empty) | (udf & ~(w_status & wb_dat_i[3]));
            thr_pend <= thr_set | (thr_pend & ~(w_status & wb_dat_i[4]));
            int_q    <= irq_en & thr_pend;
            rp       <= ra;
            coll     <= mem_we && (wp == ra);
            if (flush_q) begin
                wp       <= '0;
                head_vld <= 1'b0;
            end else begin
                if (mem_we)
                    wp <= wp + 1'b1;
                if (need_fill) begin
                    if (mem_has) begin
                        head     <= mq;
                        head_vld <= 1'b1;
                    end else if (push) begin
                        head     <= wb_dat_i;
                        head_vld <= 1'b1;
                    end else begin
                        head_vld <= 1'b0;
                    end
                end
            end
        end
    end

    // Registered-read storage; byp/coll cover a read of the address written the cycle before
    always_ff @(posedge wb_clk_i) begin
        if (mem_we)
            mem[wp] <= wb_dat_i;
        q   <= mem[ra];
        byp <= wb_dat_i;
    end
endmodule

// File: tb/tb_wbs_mbox_fifo.sv
// Directed self-checking bench for wbs_mbox_fifo (DEPTH_LOG2 = 9).
module tb_wbs_mbox_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  adr = '0;
    logic [15:0] dat_i = '0;
    logic [1:0]  sel = '0;
    logic [2:0]  cti = '0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, lock = 1'b0;
    logic [15:0] dat_o;
    logic        ack, err, rty, irq;

    wbs_mbox_fifo #(.DEPTH_LOG2(9)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
        .wb_sel_i(sel), .wb_cti_i(cti), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_we_i(we), .wb_lock_i(lock), .wb_dat_o(dat_o), .wb_ack_o(ack),
        .wb_err_o(err), .wb_rty_o(rty), .int_out(irq)
    );

    always #4 clk = ~clk;

`ifdef WBS_MBOX_ERR_EN
    localparam logic [15:0] T_BAD = 16'h0002;
`else
    localparam logic [15:0] T_BAD = 16'h0001;
`endif
    localparam logic [15:0] T_ACK = 16'h0001;

    int nchk = 0;
    int nbad = 0;
    logic [15:0] r_dat, n_dat;
    logic        r_ack, r_err, n_ack, r_irq, n_irq;
    int          b_acks, b_bad;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // One classic access; results land in r_* (termination cycle) and n_* (cycle after)
    task automatic bus(input logic w, input logic [4:0] a, input logic [15:0] d, input logic [1:0] s);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s; cti = 3'b000;
        r_ack = 1'b0; r_err = 1'b0; r_dat = '0; r_irq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack || err) begin
                r_ack = ack; r_err = err; r_dat = dat_o; r_irq = irq;
                break;
            end
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        n_ack = ack | err; n_dat = dat_o; n_irq = irq;
    endtask

    // Incrementing burst of n accesses to DATA; writes push i, reads expect i
    task automatic burst(input logic w, input int unsigned n);
        b_acks = 0; b_bad = 0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            cyc = 1'b1; stb = 1'b1; we = w; adr = 5'h00; sel = 2'b11;
            dat_i = 16'(i); cti = (i == n - 1) ? 3'b111 : 3'b010;
            @(posedge clk); #1;
            if (ack) b_acks++;
            if (!w && dat_o !== 16'(i)) b_bad++;
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        @(posedge clk); #1;
        n_ack = ack | err;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        check("rst_dat", dat_o, 16'h0000);
        check("rst_outs", {12'b0, ack, err, rty, irq}, 16'h0000);

        bus(1'b0, 5'h02, 16'h0, 2'b11);
        check("count0_term", {14'b0, r_err, r_ack}, T_ACK);
        check("count0", r_dat, 16'h0000);
        bus(1'b0, 5'h04, 16'h0, 2'b11);
        check("status0", r_dat, 16'h0001);

        bus(1'b1, 5'h00, 16'h1111, 2'b11);
        check("w1_term", {14'b0, r_err, r_ack}, T_ACK);
        check("w1_ack_len", {15'b0, n_ack}, 16'h0000);
        bus(1'b1, 5'h00, 16'h2222, 2'b11);
        bus(1'b1, 5'h00, 16'h3333, 2'b11);
        bus(1'b0, 5'h02, 16'h0, 2'b11);
        check("count3", r_dat, 16'h0003);
        bus(1'b0, 5'h00, 16'h0, 2'b11);
        check("pop1", r_dat, 16'h1111);
        check("pop1_hold0", n_dat, 16'h0000);
        check("pop1_ack_len", {15'b0, n_ack}, 16'h0000);
        bus(1'b0, 5'h00, 16'h0, 2'b11);
        check("pop2", r_dat, 16'h2222);
        bus(1'b0, 5'h00, 16'h0, 2'b11);
        check("pop3", r_dat, 16'h3333);
        bus(1'b0, 5'h02, 16'h0, 2'b11);
        check("count_back0", r_dat, 16'h0000);

        bus(1'b1, 5'h00, 16'h5555, 2'b01);
        check("partial_term", {14'b0, r_err, r_ack}, T_ACK);
        bus(1'b0, 5'h02, 16'h0, 2'b11);
        check("partial_nopush", r_dat, 16'h0000);

        bus(1'b1, 5'h0C, 16'hFFFF, 2'b11);
        check("unmapped_w_term", {14'b0, r_err, r_ack}, T_BAD);
        bus(1'b0, 5'h0A, 16'h0, 2'b11);
        check("unmapped_r_term", {14'b0, r_err, r_ack}, T_BAD);
        check("unmapped_r", r_dat, 16'h0000);

        burst(1'b1, 512);
        check("bw_acks", 16'(b_acks), 16'd512);
        check("bw_ack_drop", {15'b0, n_ack}, 16'h0000);
        bus(1'b0, 5'h02, 16'h0, 2'b11);
        check("count_full", r_dat, 16'h0200);
        bus(1'b1, 5'h00, 16'hDEAD, 2'b11);
        check("ovf_term", {14'b0, r_err, r_ack}, T_BAD);
        bus(1'b0, 5'h04, 16'h0, 2'b11);
        check("status_ovf", r_dat, 16'h0006);
        bus(1'b1, 5'h04, 16'h0004, 2'b11);
        bus(1'b0, 5'h04, 16'h0, 2'b11);
        check("status_ovf_clr", r_dat, 16'h0002);

        burst(1'b0, 512);
        check("br_acks", 16'(b_acks), 16'd512);
        check("br_data_bad", 16'(b_bad), 16'd0);
        check("br_ack_drop", {15'b0, n_ack}, 16'h0000);
        bus(1'b0, 5'h00, 16'h0, 2'b11);
        check("udf_term", {14'b0, r_err, r_ack}, T_BAD);
        check("udf_data", r_dat, 16'h0000);
        bus(1'b0, 5'h04, 16'h0, 2'b11);
        check("status_udf", r_dat, 16'h0009);
        bus(1'b1, 5'h04, 16'h0008, 2'b11);
        bus(1'b0, 5'h04, 16'h0, 2'b11);
        check("status_udf_clr", r_dat, 16'h0001);

        bus(1'b1, 5'h06, 16'h0004, 2'b11);
        bus(1'b0, 5'h06, 16'h0, 2'b11);
        check("thresh_rb", r_dat, 16'h0004);
        bus(1'b1, 5'h08, 16'h0002, 2'b11);
        bus(1'b0, 5'h08, 16'h0, 2'b11);
        check("ctrl_rb", r_dat, 16'h0002);
        bus(1'b1, 5'h00, 16'h00A0, 2'b11);
        bus(1'b1, 5'h00, 16'h00A1, 2'b11);
        bus(1'b1, 5'h00, 16'h00A2, 2'b11);
        check("irq_below_thr", {15'b0, n_irq}, 16'h0000);
        bus(1'b1, 5'h00, 16'h00A3, 2'b11);
        check("irq_at_ack", {15'b0, r_irq}, 16'h0000);
        check("irq_next", {15'b0, n_irq}, 16'h0001);
        bus(1'b0, 5'h04, 16'h0, 2'b11);
        check("status_thr", r_dat, 16'h0010);
        bus(1'b1, 5'h04, 16'h0010, 2'b11);
        check("irq_cleared", {15'b0, n_irq}, 16'h0000);
        bus(1'b0, 5'h04, 16'h0, 2'b11);
        check("status_thr_clr", r_dat, 16'h0000);

        for (int i = 0; i < 6; i++)
            bus(1'b1, 5'h00, 16'(16'h00B0 + i), 2'b11);
        bus(1'b0, 5'h02, 16'h0, 2'b11);
        check("count10", r_dat, 16'h000A);

        // Burst: CTRL flush followed by a DATA write that lands in the flush cycle
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 5'h08; sel = 2'b11; dat_i = 16'h0003; cti = 3'b010;
        @(posedge clk); #1;
        check("flush_ack", {15'b0, ack}, 16'h0001);
        @(negedge clk);
        adr = 5'h00; dat_i = 16'hBEEF; cti = 3'b111;
        @(posedge clk); #1;
        check("flush_push_ack", {15'b0, ack}, 16'h0001);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        @(posedge clk); #1;
        check("flush_burst_end", {15'b0, ack}, 16'h0000);
        bus(1'b0, 5'h02, 16'h0, 2'b11);
        check("count_flushed", r_dat, 16'h0000);
        bus(1'b0, 5'h04, 16'h0, 2'b11);
        check("status_flushed", r_dat, 16'h0001);
        bus(1'b0, 5'h08, 16'h0, 2'b11);
        check("ctrl_selfclr", r_dat, 16'h0002);

        // Reset in the middle of a write burst
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 5'h00; sel = 2'b11; dat_i = 16'h7777; cti = 3'b010;
        @(posedge clk); #1;
        @(negedge clk);
        dat_i = 16'h8888;
        @(posedge clk); #1;
        check("mid_burst_ack", {15'b0, ack}, 16'h0001);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ack", {15'b0, ack}, 16'h0000);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
        @(negedge clk); rst = 1'b0;
        bus(1'b0, 5'h02, 16'h0, 2'b11);
        check("rst_count", r_dat, 16'h0000);
        bus(1'b0, 5'h04, 16'h0, 2'b11);
        check("rst_status", r_dat, 16'h0001);
        bus(1'b0, 5'h06, 16'h0, 2'b11);
        check("rst_thresh", r_dat, 16'h0000);
        bus(1'b0, 5'h08, 16'h0, 2'b11);
        check("rst_ctrl", r_dat, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nbad);
        $finish;
    end
endmodule
